// File: rtl/fetch_redirect_controller.sv
// Fetch PC sequencer. Owns the architectural fetch PC. It advances the PC
// sequentially and accepts redirects from the trap and branch units. Each
// accepted redirect opens a fixed-length flush window. When the window
// closes, fetch resumes at the captured target.
module fetch_redirect_controller #(
  parameter int                      addressWidth = 64,
  parameter logic [addressWidth-1:0] resetVector  = '0,
  parameter int                      instrBytes   = 4,
  parameter int                      flushCycles  = 3,
  parameter int                      countWidth   = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    stall_i,
  input  logic                    is64Bit_i,
  input  logic                    fetchReady_i,
  input  logic                    branchValid_i,
  input  logic [addressWidth-1:0] branchTarget_i,
  input  logic                    trapValid_i,
  input  logic [addressWidth-1:0] trapTarget_i,
  output logic [addressWidth-1:0] PC_o,
  output logic                    fetchValid_o,
  output logic                    flush_o,
  output logic                    branchAck_o,
  output logic                    trapAck_o,
  output logic [countWidth-1:0]   redirectCount_o
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  // Redirect request after trap-over-branch arbitration and normalisation.
  typedef struct packed {
    logic                    valid;
    logic                    is_trap;
    logic [addressWidth-1:0] target;
  } redirect_t;

  // Mask that keeps only the low 32 bits. Used in 32-bit mode.
  function automatic logic [addressWidth-1:0] low32_mask();
    logic [addressWidth-1:0] m;
    for (int i = 0; i < addressWidth; i++) m[i] = (i < 32);
    return m;
  endfunction

  localparam logic [addressWidth-1:0] LOW32_MASK   = low32_mask();
  localparam logic [addressWidth-1:0] PC_STEP      = addressWidth'(instrBytes);
  localparam logic [3:0]              FLUSH_RELOAD = 4'(flushCycles - 1);
  localparam logic [countWidth-1:0]   COUNT_ONE    = countWidth'(1);

  // Clear the alignment bits. In 32-bit mode, also drop everything above bit 31.
  // The 32-bit wrap of a sequential add also falls out of this mask.
  function automatic logic [addressWidth-1:0] normalise(
    input logic [addressWidth-1:0] addr,
    input logic                    mode64
  );
    logic [addressWidth-1:0] r;
    r      = addr;
    r[1:0] = 2'b00;
    if (!mode64) r = r & LOW32_MASK;
    return r;
  endfunction

  state_t                  state;
  logic [3:0]              flush_cnt;
  logic [addressWidth-1:0] target_q;
  redirect_t               req;
  logic [addressWidth-1:0] pc_seq;
  logic [countWidth-1:0]   count_next;

  // Arbitrate the two redirect sources. A trap always wins; a branch that
  // arrives in the same cycle as a trap is dropped.
  always_comb begin
    req = '0;
    if (trapValid_i) begin
      req.valid   = 1'b1;
      req.is_trap = 1'b1;
      req.target  = normalise(trapTarget_i, is64Bit_i);
    end else if (branchValid_i) begin
      req.valid   = 1'b1;
      req.is_trap = 1'b0;
      req.target  = normalise(branchTarget_i, is64Bit_i);
    end
  end

  // Next sequential PC, and the redirect count saturated at all-ones.
  always_comb begin
    pc_seq     = normalise(PC_o + PC_STEP, is64Bit_i);
    count_next = (&redirectCount_o) ? redirectCount_o : redirectCount_o + COUNT_ONE;
  end

  // Main sequencer: BOOT -> RUN, with RUN <-> FLUSH on redirects. All outputs are registered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= BOOT;
      PC_o            <= resetVector;
      fetchValid_o    <= 1'b0;
      flush_o         <= 1'b0;
      branchAck_o     <= 1'b0;
      trapAck_o       <= 1'b0;
      redirectCount_o <= '0;
      target_q        <= '0;
      flush_cnt       <= '0;
    end else begin
      // Acks are single-cycle pulses. Any cycle that does not accept a redirect clears them.
      branchAck_o <= 1'b0;
      trapAck_o   <= 1'b0;
      case (state)
        // One dead cycle after reset. Any request that arrives here is discarded.
        BOOT: begin
          state        <= RUN;
          fetchValid_o <= 1'b1;
        end
        RUN: begin
          if (req.valid) begin
            // A redirect is taken even while stalled.
            state           <= FLUSH;
            target_q        <= req.target;
            flush_cnt       <= FLUSH_RELOAD;
            flush_o         <= 1'b1;
            fetchValid_o    <= 1'b0;
            redirectCount_o <= count_next;
            trapAck_o       <= req.is_trap;
            branchAck_o     <= !req.is_trap;
          end else if (fetchReady_i && !stall_i) begin
            PC_o <= pc_seq;
          end
        end
        FLUSH: begin
          if (trapValid_i) begin
            // A trap restarts the window with its own target. A branch seen
            // here is younger than the flush, so it is squashed with no ack.
            target_q        <= req.target;
            flush_cnt       <= FLUSH_RELOAD;
            trapAck_o       <= 1'b1;
            redirectCount_o <= count_next;
          end else if (flush_cnt == 4'd0) begin
            state        <= RUN;
            PC_o         <= target_q;
            flush_o      <= 1'b0;
            fetchValid_o <= 1'b1;
          end else begin
            // The window drains at a fixed rate; stall_i has no effect here.
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Directed bench for fetch_redirect_controller. It uses resetVector=0x100,
// flushCycles=3, and a 3-bit redirect counter so that saturation is reachable.
module tb_fetch_redirect_controller;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        stall_i;
  logic        is64Bit_i;
  logic        fetchReady_i;
  logic        branchValid_i;
  logic [63:0] branchTarget_i;
  logic        trapValid_i;
  logic [63:0] trapTarget_i;
  logic [63:0] PC_o;
  logic        fetchValid_o;
  logic        flush_o;
  logic        branchAck_o;
  logic        trapAck_o;
  logic [2:0]  redirectCount_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_redirect_controller #(
    .addressWidth(64),
    .resetVector (64'h100),
    .instrBytes  (4),
    .flushCycles (3),
    .countWidth  (3)
  ) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .stall_i        (stall_i),
    .is64Bit_i      (is64Bit_i),
    .fetchReady_i   (fetchReady_i),
    .branchValid_i  (branchValid_i),
    .branchTarget_i (branchTarget_i),
    .trapValid_i    (trapValid_i),
    .trapTarget_i   (trapTarget_i),
    .PC_o           (PC_o),
    .fetchValid_o   (fetchValid_o),
    .flush_o        (flush_o),
    .branchAck_o    (branchAck_o),
    .trapAck_o      (trapAck_o),
    .redirectCount_o(redirectCount_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] pc, input logic fv,
                     input logic fl, input logic ba, input logic ta, input logic [2:0] cnt);
    check({tag, ".pc"},    PC_o,                    pc);
    check({tag, ".fv"},    {63'd0, fetchValid_o},   {63'd0, fv});
    check({tag, ".flush"}, {63'd0, flush_o},        {63'd0, fl});
    check({tag, ".bAck"},  {63'd0, branchAck_o},    {63'd0, ba});
    check({tag, ".tAck"},  {63'd0, trapAck_o},      {63'd0, ta});
    check({tag, ".cnt"},   {61'd0, redirectCount_o}, {61'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; stall_i = 1'b0; is64Bit_i = 1'b1; fetchReady_i = 1'b0;
    branchValid_i = 1'b0; branchTarget_i = '0; trapValid_i = 1'b0; trapTarget_i = '0;
    #12;
    chk("reset", 64'h100, 0, 0, 0, 0, 0);

    // BOOT: release reset with a branch pending; it must be ignored.
    reset_i = 1'b0; branchValid_i = 1'b1; branchTarget_i = 64'h4000;
    #1;
    chk("boot", 64'h100, 0, 0, 0, 0, 0);
    tick();
    chk("boot_exit", 64'h100, 1, 0, 0, 0, 0);
    branchValid_i = 1'b0; fetchReady_i = 1'b1;
    tick(); chk("seq0", 64'h104, 1, 0, 0, 0, 0);
    tick(); chk("seq1", 64'h108, 1, 0, 0, 0, 0);
    tick(); chk("seq2", 64'h10C, 1, 0, 0, 0, 0);
    fetchReady_i = 1'b0;

    // Branch redirect with an unaligned target.
    branchValid_i = 1'b1; branchTarget_i = 64'h2003;
    tick(); chk("br_acc", 64'h10C, 0, 1, 1, 0, 1);
    branchValid_i = 1'b0;
    tick(); chk("br_fl2", 64'h10C, 0, 1, 0, 0, 1);
    tick(); chk("br_fl3", 64'h10C, 0, 1, 0, 0, 1);
    tick(); chk("br_done", 64'h2000, 1, 0, 0, 0, 1);

    // Simultaneous requests: the trap wins.
    branchValid_i = 1'b1; branchTarget_i = 64'h5000;
    trapValid_i = 1'b1; trapTarget_i = 64'h700;
    tick(); chk("both_acc", 64'h2000, 0, 1, 0, 1, 2);
    branchValid_i = 1'b0; trapValid_i = 1'b0;
    tick(); chk("both_fl2", 64'h2000, 0, 1, 0, 0, 2);
    // A trap during FLUSH restarts the window.
    trapValid_i = 1'b1; trapTarget_i = 64'h900;
    tick(); chk("trapfl_acc", 64'h2000, 0, 1, 0, 1, 3);
    trapValid_i = 1'b0; branchValid_i = 1'b1; branchTarget_i = 64'h3000;
    tick(); chk("brfl_drop", 64'h2000, 0, 1, 0, 0, 3);
    branchValid_i = 1'b0;
    tick(); chk("trapfl_3", 64'h2000, 0, 1, 0, 0, 3);
    tick(); chk("trapfl_done", 64'h900, 1, 0, 0, 0, 3);

    // 32-bit mode: sequential wrap and truncation of the upper target bits.
    is64Bit_i = 1'b0; branchValid_i = 1'b1; branchTarget_i = 64'hFFFF_FFFF;
    tick(); chk("m32_acc", 64'h900, 0, 1, 1, 0, 4);
    branchValid_i = 1'b0;
    tick(); tick();
    tick(); chk("m32_pc", 64'hFFFF_FFFC, 1, 0, 0, 0, 4);
    fetchReady_i = 1'b1;
    tick(); chk("m32_wrap", 64'h0, 1, 0, 0, 0, 4);
    fetchReady_i = 1'b0; branchValid_i = 1'b1; branchTarget_i = 64'h1_0000_0040;
    tick(); chk("m32_br", 64'h0, 0, 1, 1, 0, 5);
    branchValid_i = 1'b0;
    tick(); tick();
    tick(); chk("m32_trunc", 64'h40, 1, 0, 0, 0, 5);

    // Stall holds the PC, but a redirect is still taken.
    is64Bit_i = 1'b1; stall_i = 1'b1; fetchReady_i = 1'b1;
    tick(); chk("stall_hold0", 64'h40, 1, 0, 0, 0, 5);
    tick(); chk("stall_hold1", 64'h40, 1, 0, 0, 0, 5);
    branchValid_i = 1'b1; branchTarget_i = 64'h8000;
    tick(); chk("stall_br", 64'h40, 0, 1, 1, 0, 6);
    branchValid_i = 1'b0;
    tick(); chk("stall_fl2", 64'h40, 0, 1, 0, 0, 6);
    tick(); chk("stall_fl3", 64'h40, 0, 1, 0, 0, 6);
    tick(); chk("stall_done", 64'h8000, 1, 0, 0, 0, 6);
    tick(); chk("stall_hold2", 64'h8000, 1, 0, 0, 0, 6);
    stall_i = 1'b0;
    tick(); chk("unstall", 64'h8004, 1, 0, 0, 0, 6);
    fetchReady_i = 1'b0;

    // The counter saturates at 7; the second trap still pulses its ack.
    trapValid_i = 1'b1; trapTarget_i = 64'hB000;
    tick(); chk("sat_acc", 64'h8004, 0, 1, 0, 1, 7);
    trapTarget_i = 64'hC000;
    tick(); chk("sat_hold", 64'h8004, 0, 1, 0, 1, 7);
    trapValid_i = 1'b0;
    tick(); tick();
    tick(); chk("sat_done", 64'hC000, 1, 0, 0, 0, 7);

    // Asynchronous reset in the second flush cycle.
    branchValid_i = 1'b1; branchTarget_i = 64'hA000;
    tick(); chk("ar_acc", 64'hC000, 0, 1, 1, 0, 7);
    branchValid_i = 1'b0;
    tick(); chk("ar_fl2", 64'hC000, 0, 1, 0, 0, 7);
    #2 reset_i = 1'b1;
    #1 chk("ar_async", 64'h100, 0, 0, 0, 0, 0);
    trapValid_i = 1'b1; trapTarget_i = 64'hD000;
    tick(); chk("ar_held", 64'h100, 0, 0, 0, 0, 0);
    reset_i = 1'b0;
    tick(); chk("ar_boot_exit", 64'h100, 1, 0, 0, 0, 0);
    trapValid_i = 1'b0;
    tick(); chk("ar_idle", 64'h100, 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
